// File: rtl/irq_ctrl.sv
//==============================================================================
// Module   : irq_ctrl
// Function : 65C02 bus-mapped interrupt controller, up to 8 sources onto IRQ/NMI.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               PHI_2,
  input  logic               RES,
  input  logic [15:0]        AB,
  input  logic [7:0]         DB_IN,
  input  logic               RW,
  output logic [7:0]         DB_OUT,
  output logic               DB_OE,
  input  logic [NUM_IRQ-1:0] SRC,
  output logic               IRQ_N,
  output logic               NMI_N
);

  localparam logic [2:0] c_OFF_PEND   = 3'd0;
  localparam logic [2:0] c_OFF_MASK   = 3'd1;
  localparam logic [2:0] c_OFF_MODE   = 3'd2;
  localparam logic [2:0] c_OFF_NMISEL = 3'd3;
  localparam logic [2:0] c_OFF_VEC    = 3'd4;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] stored_q, stored_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] nmisel_q, nmisel_d;
  logic               irq_n_q, irq_n_d;
  logic               nmi_n_q, nmi_n_d;

  logic               w_hit;
  logic               w_wr_en;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_synced;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_mode_chg;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_active;
  logic [2:0]         w_vec_idx;
  logic               w_vec_any;
  logic [7:0]         w_rdata;

  assign w_hit    = (AB[15:3] == BASE_ADDR[15:3]);
  assign w_wr_en  = w_hit & ~RW;
  assign w_wdata  = DB_IN[NUM_IRQ-1:0];
  assign w_synced = sync_q[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~prev_q & mode_q;

  // Level channels report the delayed level so both modes share one latency.
  assign w_pend   = (mode_q & stored_q) | (~mode_q & prev_q);
  assign w_active = w_pend & mask_q;

  always_comb begin
    mask_d     = mask_q;
    mode_d     = mode_q;
    nmisel_d   = nmisel_q;
    w_w1c      = '0;
    w_mode_chg = '0;
    if (w_wr_en) begin
      case (AB[2:0])
        c_OFF_PEND:   w_w1c = w_wdata & mode_q;
        c_OFF_MASK:   mask_d = w_wdata;
        c_OFF_MODE: begin
          mode_d     = w_wdata;
          w_mode_chg = w_wdata ^ mode_q;
        end
        c_OFF_NMISEL: nmisel_d = w_wdata;
        default:      ;
      endcase
    end
    // Set wins over a same-cycle clear.
    stored_d = (stored_q & ~w_w1c & ~w_mode_chg) | w_rise;
    irq_n_d  = ~|(w_active & ~nmisel_q);
    nmi_n_d  = ~|(w_active & nmisel_q);
  end

  always_ff @(posedge PHI_2) begin
    if (RES) begin
      sync_q   <= '0;
      prev_q   <= '0;
      stored_q <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      nmisel_q <= '0;
      irq_n_q  <= 1'b1;
      nmi_n_q  <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], SRC};
      prev_q   <= w_synced;
      stored_q <= stored_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      nmisel_q <= nmisel_d;
      irq_n_q  <= irq_n_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  // Descending scan so the lowest-indexed active channel wins.
  always_comb begin
    w_vec_idx = 3'd0;
    w_vec_any = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vec_idx = 3'(i);
        w_vec_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (AB[2:0])
      c_OFF_PEND:   w_rdata = 8'(w_pend);
      c_OFF_MASK:   w_rdata = 8'(mask_q);
      c_OFF_MODE:   w_rdata = 8'(mode_q);
      c_OFF_NMISEL: w_rdata = 8'(nmisel_q);
      c_OFF_VEC:    w_rdata = {~w_vec_any, 4'b0000, w_vec_idx};
      default:      w_rdata = 8'h00;
    endcase
  end

  assign DB_OE  = w_hit & RW;
  assign DB_OUT = DB_OE ? w_rdata : 8'h00;
  assign IRQ_N  = irq_n_q;
  assign NMI_N  = nmi_n_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
//==============================================================================
// Module   : tb_irq_ctrl
// Function : Directed, table-driven self-checking bench for irq_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] ab;
  logic [7:0]  db_in;
  logic        rw;
  logic [7:0]  src;
  logic [2:0]  src3;
  logic [7:0]  db_out, db_out3;
  logic        db_oe, db_oe3;
  logic        irq_n, nmi_n, irq_n3, nmi_n3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NUM_IRQ(8), .BASE_ADDR(16'hD000), .SYNC_STAGES(2)) u_dut (
    .PHI_2(clk), .RES(res), .AB(ab), .DB_IN(db_in), .RW(rw),
    .DB_OUT(db_out), .DB_OE(db_oe), .SRC(src), .IRQ_N(irq_n), .NMI_N(nmi_n)
  );

  irq_ctrl #(.NUM_IRQ(3), .BASE_ADDR(16'hD000), .SYNC_STAGES(2)) u_dut3 (
    .PHI_2(clk), .RES(res), .AB(ab), .DB_IN(db_in), .RW(rw),
    .DB_OUT(db_out3), .DB_OE(db_oe3), .SRC(src3), .IRQ_N(irq_n3), .NMI_N(nmi_n3)
  );

  typedef struct {
    logic [15:0] ab;
    logic        rw;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    ab = a; db_in = d; rw = 1'b0;
    tick();
    rw = 1'b1; ab = 16'h0000;
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    ab = a; rw = 1'b1;
    #1;
    check(name, db_out, exp);
  endtask

  task automatic read_chk3(input string name, input logic [15:0] a, input logic [7:0] exp);
    ab = a; rw = 1'b1;
    #1;
    check(name, db_out3, exp);
  endtask

  initial begin
    tbl[0]  = '{16'hD000, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{16'hD001, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[2]  = '{16'hD002, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{16'hD003, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{16'hD004, 1'b1, 8'h00, 8'h80, 1'b1};
    tbl[5]  = '{16'hD005, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{16'hD006, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{16'hD007, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{16'hD008, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{16'hCFFF, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{16'hD001, 1'b0, 8'hA5, 8'h00, 1'b0};
    tbl[11] = '{16'hD001, 1'b1, 8'h00, 8'hA5, 1'b1};
    tbl[12] = '{16'hD002, 1'b0, 8'h3C, 8'h00, 1'b0};
    tbl[13] = '{16'hD002, 1'b1, 8'h00, 8'h3C, 1'b1};
    tbl[14] = '{16'hD003, 1'b0, 8'h81, 8'h00, 1'b0};
    tbl[15] = '{16'hD003, 1'b1, 8'h00, 8'h81, 1'b1};
    tbl[16] = '{16'hD005, 1'b0, 8'hFF, 8'h00, 1'b0};
    tbl[17] = '{16'hD005, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[18] = '{16'hD000, 1'b0, 8'hFF, 8'h00, 1'b0};
    tbl[19] = '{16'hD000, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[20] = '{16'hD001, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[21] = '{16'hD002, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[22] = '{16'hD003, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[23] = '{16'hD004, 1'b1, 8'h00, 8'h80, 1'b1};

    res = 1'b1; ab = 16'h0000; db_in = 8'h00; rw = 1'b1; src = 8'h00; src3 = 3'b000;
    tick(); tick();
    res = 1'b0;
    tick();

    check("reset_irq_n", {7'b0, irq_n}, 8'h01);
    check("reset_nmi_n", {7'b0, nmi_n}, 8'h01);

    for (int i = 0; i < 24; i++) begin
      ab = tbl[i].ab; rw = tbl[i].rw; db_in = tbl[i].din;
      #1;
      check($sformatf("tbl%0d_dout", i), db_out, tbl[i].dout);
      check($sformatf("tbl%0d_oe", i), {7'b0, db_oe}, {7'b0, tbl[i].oe});
      if (!tbl[i].rw) tick();
      rw = 1'b1;
    end
    check("tbl_irq_idle", {7'b0, irq_n}, 8'h01);

    // Level channel 0
    bus_write(16'hD001, 8'h01);
    src[0] = 1'b1;
    tick();
    check("lvl_e1_irq", {7'b0, irq_n}, 8'h01);
    tick(); tick();
    check("lvl_e3_irq", {7'b0, irq_n}, 8'h01);
    read_chk("lvl_e3_pend", 16'hD000, 8'h01);
    tick();
    check("lvl_e4_irq", {7'b0, irq_n}, 8'h00);
    read_chk("lvl_vec", 16'hD004, 8'h00);
    bus_write(16'hD000, 8'h01);
    read_chk("lvl_w1c_ignored", 16'hD000, 8'h01);
    src[0] = 1'b0;
    tick(); tick(); tick();
    check("lvl_fall_e3_irq", {7'b0, irq_n}, 8'h00);
    tick();
    check("lvl_fall_e4_irq", {7'b0, irq_n}, 8'h01);
    bus_write(16'hD001, 8'h00);

    // Edge channel 3
    bus_write(16'hD001, 8'h08);
    bus_write(16'hD002, 8'h08);
    src[3] = 1'b1;
    tick();
    src[3] = 1'b0;
    tick(); tick();
    read_chk("edge_e3_pend", 16'hD000, 8'h08);
    tick();
    check("edge_e4_irq", {7'b0, irq_n}, 8'h00);
    tick(); tick(); tick();
    read_chk("edge_pend_hold", 16'hD000, 8'h08);
    read_chk("edge_vec", 16'hD004, 8'h03);
    bus_write(16'hD000, 8'h08);
    read_chk("edge_w1c_pend", 16'hD000, 8'h00);
    check("edge_w1c_irq_lag", {7'b0, irq_n}, 8'h00);
    tick();
    check("edge_w1c_irq", {7'b0, irq_n}, 8'h01);
    src[3] = 1'b1;
    tick();
    src[3] = 1'b0;
    tick();
    bus_write(16'hD000, 8'h08);
    read_chk("edge_set_wins", 16'hD000, 8'h08);
    bus_write(16'hD000, 8'h08);
    read_chk("edge_reclear", 16'hD000, 8'h00);
    bus_write(16'hD001, 8'h00);
    bus_write(16'hD002, 8'h00);

    // Priority and masking
    bus_write(16'hD002, 8'h24);
    src = 8'h24;
    tick();
    src = 8'h00;
    tick(); tick(); tick();
    read_chk("prio_pend", 16'hD000, 8'h24);
    bus_write(16'hD001, 8'h20);
    read_chk("prio_vec5", 16'hD004, 8'h05);
    tick();
    check("prio_irq_on", {7'b0, irq_n}, 8'h00);
    bus_write(16'hD001, 8'h24);
    read_chk("prio_vec2", 16'hD004, 8'h02);
    bus_write(16'hD001, 8'h00);
    read_chk("prio_vec_none", 16'hD004, 8'h80);
    tick();
    check("prio_masked_irq", {7'b0, irq_n}, 8'h01);
    read_chk("prio_masked_pend", 16'hD000, 8'h24);
    bus_write(16'hD002, 8'h00);
    read_chk("mode_chg_clears", 16'hD000, 8'h00);

    // NMI routing
    bus_write(16'hD003, 8'h02);
    bus_write(16'hD001, 8'h03);
    src = 8'h03;
    repeat (4) tick();
    check("nmi_on", {7'b0, nmi_n}, 8'h00);
    check("nmi_irq_on", {7'b0, irq_n}, 8'h00);
    bus_write(16'hD001, 8'h02);
    tick();
    check("nmi_irq_masked", {7'b0, irq_n}, 8'h01);
    check("nmi_stays", {7'b0, nmi_n}, 8'h00);
    src = 8'h00;
    bus_write(16'hD001, 8'h00);
    bus_write(16'hD003, 8'h00);
    tick();
    check("nmi_off", {7'b0, nmi_n}, 8'h01);

    // NUM_IRQ=3 instance: width clipping and reset overriding a write/edge
    bus_write(16'hD001, 8'hFF);
    read_chk3("n3_mask_clip", 16'hD001, 8'h07);
    read_chk("n8_mask_full", 16'hD001, 8'hFF);
    bus_write(16'hD002, 8'h04);
    read_chk3("n3_mode", 16'hD002, 8'h04);
    src3 = 3'b100;
    tick();
    src3 = 3'b000;
    tick();
    res = 1'b1; ab = 16'hD001; db_in = 8'h55; rw = 1'b0;
    tick();
    res = 1'b0; rw = 1'b1;
    read_chk3("n3_rst_pend", 16'hD000, 8'h00);
    read_chk3("n3_rst_mask", 16'hD001, 8'h00);
    read_chk3("n3_rst_mode", 16'hD002, 8'h00);
    read_chk3("n3_rst_vec", 16'hD004, 8'h80);
    check("n3_rst_irq", {7'b0, irq_n3}, 8'h01);
    check("n3_rst_nmi", {7'b0, nmi_n3}, 8'h01);
    repeat (4) tick();
    read_chk3("n3_post_pend", 16'hD000, 8'h00);
    check("n3_post_irq", {7'b0, irq_n3}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller on the 65C02 system bus: aggregates up to 8 external interrupt sources into the core's active-low IRQ and NMI inputs. Per-channel mask, edge/level mode and NMI routing, plus a priority vector register, all memory-mapped at a parameterised base address. Sits between peripherals and the CPU core, decoded directly from the core's address/data bus.

## Interface

- NUM_IRQ, 8: number of source channels, 1..8.
- BASE_ADDR, 16'hD000: register block base; low 3 bits must be 0.
- SYNC_STAGES, 2: synchroniser depth per source, ≥2.

- PHI_2  in  1  clock; all state updates on rising edge. One clock.
- RES  in  1  reset, synchronous, active-high.
- AB  in  16  CPU address bus.
- DB_IN  in  8  CPU write data.
- RW  in  1  1 = read, 0 = write.
- DB_OUT  out  8  read data.
- DB_OE  out  1  high when DB_OUT must drive the bus.
- SRC  in  NUM_IRQ  asynchronous interrupt sources, active-high.
- IRQ_N  out  1  to core IRQ, active-low, registered.
- NMI_N  out  1  to core NMI, active-low, registered.

## Operation

- Hit = AB[15:3] == BASE_ADDR[15:3]; offset = AB[2:0].
- Write on rising PHI_2 when hit & RW=0. Read combinational: DB_OE = hit & RW; DB_OUT = selected register, 8'h00 otherwise. Reads have no side effects.
- Registers (bits ≥ NUM_IRQ read 0, writes ignored):
  - 0 PEND, R: pending; W: write-1-clears edge-mode bits. Level-mode bits ignore writes.
  - 1 MASK, R/W, 1 = enabled, reset 00.
  - 2 MODE, R/W, 1 = rising-edge, 0 = level-high, reset 00.
  - 3 NMISEL, R/W, 1 = channel routes to NMI instead of IRQ, reset 00.
  - 4 VEC, R: bit7 = no enabled pending channel; bits2:0 = lowest-indexed channel with PEND & MASK. Reads 8'h80 when none.
  - 5..7 reserved: read 00, writes ignored.
- Per channel: SYNC_STAGES-flop synchroniser, then a prev flop for edge detect.
- Level mode: PEND bit equals the synchronised level.
- Edge mode: a stored bit is set on synced rising edge and cleared by W1C. A simultaneous set and clear leaves it set.
- A MODE write clears the stored edge bit of every channel whose mode bit changes.
- IRQ_N next = ~|(PEND & MASK & ~NMISEL); NMI_N next = ~|(PEND & MASK & NMISEL). Both are level, held until software clears or masks.
- Reset: all registers, synchroniser, prev and stored bits go to 0; IRQ_N = 1, NMI_N = 1. A source already high at reset release is seen as a rising edge.

## Timing

- Source to output, counting the first edge that samples SRC high as edge 1:
  - synced bit high after edge SYNC_STAGES;
  - PEND set after edge SYNC_STAGES+1;
  - IRQ_N/NMI_N low after edge SYNC_STAGES+2 (edge 4 at default).
- Register write visible on DB_OUT on the cycle after the write edge. IRQ_N/NMI_N reflect a MASK/NMISEL/PEND write one edge later.
- An edge pulse must be high for ≥1 PHI_2 period to be captured. Pulses shorter than that may be missed.
- RES asserted mid-operation overrides any same-cycle write or source edge.

## Test plan

- Reset defaults: after RES, read offsets 0..7 → 00,00,00,00,80,00,00,00; IRQ_N=1, NMI_N=1; read at BASE_ADDR+8 → DB_OE=0.
- Level channel: MASK=01, MODE=00, SRC[0] rises at edge 1 → IRQ_N low after edge 4; VEC=00. SRC[0] falls → IRQ_N high 4 edges later; W1C to PEND has no effect.
- Edge channel: MASK=08, MODE=08, pulse SRC[3] for 1 cycle → PEND=08 persists, IRQ_N low, VEC=03. Write PEND=08 → PEND=00, IRQ_N high next edge. Re-pulse coinciding with a W1C edge → PEND stays 08.
- Priority/mask: SRC[5] and SRC[2] edges, MASK=20 → VEC=05. MASK=24 → VEC=02. MASK=00 → VEC=80, IRQ_N=1 while PEND=24.
- NMI routing: NMISEL=02, MASK=03, SRC[1] and SRC[0] high → NMI_N=0 and IRQ_N=0. Clear MASK bit0 → IRQ_N=1, NMI_N stays 0.
- NUM_IRQ=3 build: write FF to MASK → reads 07. SRC[2] edge then RES asserted same cycle as write → all zero, outputs deasserted.
